// File: rtl/xor_nn_input_cond.sv
// xor_nn_input_cond: syncs and debounces the MKR header pins, then issues one start pulse per press with held operands.
// The WAIT watchdog is built only when XOR_NN_TIMEOUT_EN is defined.
module xor_nn_input_cond #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int TIMEOUT_CYCLES  = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_n_pin,
   input  logic       x1_pin,
   input  logic       x2_pin,
   input  logic       nn_done,
   output logic       nn_start,
   output logic       nn_x1,
   output logic       nn_x2,
   output logic       busy,
   output logic [7:0] req_count,
   output logic       timeout
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   // Inactive level per conditioned pin: bit0 start_n (idle high), bit1 x1, bit2 x2.
   localparam logic [2:0] IDLE_LVL = 3'b001;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLDOFF} state_t;

   logic [2:0] w_pins;
   logic [2:0] w_db;
   logic       w_fall;
   logic       w_to_hit;
   state_t     r_state;
   state_t     w_next;
   logic       r_db_start_prev;
   logic       r_nn_start;
   logic       r_nn_x1;
   logic       r_nn_x2;
   logic       r_busy;
   logic [7:0] r_req_count;

   assign w_pins = {x2_pin, x1_pin, start_n_pin};

   for (genvar g = 0; g < 3; g++) begin : g_cond
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CW-1:0]          r_cnt;
      logic                   r_prev;
      logic                   r_db;
      logic                   w_synced;
      assign w_synced = r_sync[SYNC_STAGES-1];
      assign w_db[g]  = r_db;
      // Plain flop chain into the clock domain.
      always_ff @(posedge clk)
         if (rst) r_sync <= {SYNC_STAGES{IDLE_LVL[g]}};
         else     r_sync <= {r_sync[SYNC_STAGES-2:0], w_pins[g]};
      // Debounced level follows the synced level only after DEBOUNCE_CYCLES unchanged cycles.
      always_ff @(posedge clk)
         if (rst) begin
            r_prev <= IDLE_LVL[g];
            r_db   <= IDLE_LVL[g];
            r_cnt  <= '0;
         end else begin
            r_prev <= w_synced;
            if (w_synced == r_db || w_synced != r_prev) r_cnt <= '0;
            else if (r_cnt == DB_LAST) begin
               r_db  <= w_synced;
               r_cnt <= '0;
            end else r_cnt <= r_cnt + CW'(1);
         end
   end

   assign w_fall = r_db_start_prev & ~w_db[0];

`ifdef XOR_NN_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_to_cnt;
   logic        r_timeout;
   assign w_to_hit = (r_state == S_WAIT) && !nn_done && (r_to_cnt == TO_LAST);
   assign timeout  = r_timeout;
   // Watchdog counts WAIT cycles; the flag sticks until the next launch.
   always_ff @(posedge clk)
      if (rst) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == S_LAUNCH)    r_to_cnt <= '0;
         else if (r_state == S_WAIT) r_to_cnt <= r_to_cnt + 16'd1;
         if (w_next == S_LAUNCH)     r_timeout <= 1'b0;
         else if (w_to_hit)          r_timeout <= 1'b1;
      end
`else
   assign w_to_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   // Next-state decode; a held button parks in HOLDOFF so it cannot retrigger.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    w_next = w_fall ? S_LAUNCH : S_IDLE;
         S_LAUNCH:  w_next = S_WAIT;
         S_WAIT:    w_next = (nn_done || w_to_hit) ? S_HOLDOFF : S_WAIT;
         S_HOLDOFF: w_next = w_db[0] ? S_IDLE : S_HOLDOFF;
         default:   w_next = S_IDLE;
      endcase
   end

   // State register plus registered Moore outputs, operand latch and launch counter.
   always_ff @(posedge clk)
      if (rst) begin
         r_state         <= S_IDLE;
         r_db_start_prev <= 1'b1;
         r_nn_start      <= 1'b0;
         r_busy          <= 1'b0;
         r_nn_x1         <= 1'b0;
         r_nn_x2         <= 1'b0;
         r_req_count     <= '0;
      end else begin
         r_state         <= w_next;
         r_db_start_prev <= w_db[0];
         r_nn_start      <= (w_next == S_LAUNCH);
         r_busy          <= (w_next != S_IDLE);
         if (r_state == S_IDLE && w_fall) begin
            r_nn_x1 <= w_db[1];
            r_nn_x2 <= w_db[2];
         end
         if (w_next == S_LAUNCH) r_req_count <= r_req_count + 8'd1;
      end

   assign nn_start  = r_nn_start;
   assign nn_x1     = r_nn_x1;
   assign nn_x2     = r_nn_x2;
   assign busy      = r_busy;
   assign req_count = r_req_count;
endmodule

// File: tb/tb_xor_nn_input_cond.sv
// tb_xor_nn_input_cond: scoreboard bench for the pin conditioner (SYNC 2, DEBOUNCE 8, TIMEOUT 100).
module tb_xor_nn_input_cond;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_n_pin = 1'b1;
   logic       x1_pin = 1'b0;
   logic       x2_pin = 1'b0;
   logic       nn_done = 1'b0;
   logic       nn_start;
   logic       nn_x1;
   logic       nn_x2;
   logic       busy;
   logic       timeout;
   logic [7:0] req_count;

   int n_checks = 0;
   int n_errors = 0;
   int n_pulses = 0;

   typedef struct {
      logic       x1;
      logic       x2;
      logic [7:0] cnt;
   } exp_t;
   exp_t       q[$];
   logic [7:0] m_count = 8'd0;

   always #5 clk = ~clk;

   xor_nn_input_cond #(
      .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(8),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start_n_pin(start_n_pin),
      .x1_pin(x1_pin),
      .x2_pin(x2_pin),
      .nn_done(nn_done),
      .nn_start(nn_start),
      .nn_x1(nn_x1),
      .nn_x2(nn_x2),
      .busy(busy),
      .req_count(req_count),
      .timeout(timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Every launch pops the oldest expectation and checks operands, count and busy.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && nn_start) begin
         n_pulses++;
         check("sb_nonempty", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("nn_x1", 32'(nn_x1), 32'(e.x1));
            check("nn_x2", 32'(nn_x2), 32'(e.x2));
            check("req_count_launch", 32'(req_count), 32'(e.cnt));
         end
         check("busy_launch", 32'(busy), 32'd1);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      q.delete();
      m_count = 8'd0;
   endtask

   task automatic wait_pulse(input string tag);
      int lat;
      for (lat = 1; lat <= 40; lat++) begin
         tick(1);
         if (nn_start) break;
      end
      check({tag, "_latency"}, 32'(lat), 32'd12);
      check("timeout_at_launch", 32'(timeout), 32'd0);
   endtask

   task automatic press(input logic x1, input logic x2, input bit bounce);
      x1_pin = x1;
      x2_pin = x2;
      tick(12);
      if (bounce)
         for (int i = 0; i < 10; i++) begin
            start_n_pin = i[0];
            tick(3);
         end
      m_count = m_count + 8'd1;
      q.push_back('{x1, x2, m_count});
      start_n_pin = 1'b0;
      wait_pulse("press");
   endtask

   task automatic done(input int d);
      tick(d);
      nn_done = 1'b1;
      tick(1);
      nn_done = 1'b0;
   endtask

   task automatic release_btn();
      start_n_pin = 1'b1;
      tick(14);
      check("busy_after_release", 32'(busy), 32'd0);
   endtask

   initial begin
      int p0;
      tick(2);
      do_reset();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_nn_start", 32'(nn_start), 32'd0);
      check("rst_nn_x1", 32'(nn_x1), 32'd0);
      check("rst_req_count", 32'(req_count), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);

      // Clean press, done after 5 cycles, button held then released.
      press(1'b1, 1'b0, 1'b0);
      done(5);
      tick(2);
      check("holdoff_busy", 32'(busy), 32'd1);
      release_btn();
      check("t1_req_count", 32'(req_count), 32'd1);

      // Bouncing button settles low: exactly one launch.
      do_reset();
      p0 = n_pulses;
      press(1'b0, 1'b1, 1'b1);
      done(2);
      tick(20);
      check("bounce_pulses", 32'(n_pulses - p0), 32'd1);
      release_btn();
      check("t2_req_count", 32'(req_count), 32'd1);

      // Operands held while pins toggle; held button never retriggers.
      do_reset();
      p0 = n_pulses;
      press(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         x1_pin = ~x1_pin;
         x2_pin = ~x2_pin;
         tick(2);
      end
      tick(12);
      check("hold_nn_x1", 32'(nn_x1), 32'd1);
      check("hold_nn_x2", 32'(nn_x2), 32'd1);
      done(1);
      tick(30);
      check("held_pulses", 32'(n_pulses - p0), 32'd1);
      check("hold_after_done_x1", 32'(nn_x1), 32'd1);
      release_btn();
      press(1'b0, 1'b1, 1'b0);
      done(1);
      release_btn();

      // Reset in WAIT abandons the request; held pin relaunches once.
      press(1'b0, 1'b1, 1'b0);
      tick(3);
      do_reset();
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_x1", 32'(nn_x1), 32'd0);
      check("mid_rst_x2", 32'(nn_x2), 32'd0);
      check("mid_rst_req", 32'(req_count), 32'd0);
      check("mid_rst_start", 32'(nn_start), 32'd0);
      m_count = 8'd1;
      q.push_back('{1'b0, 1'b1, m_count});
      wait_pulse("rst_relaunch");
      done(2);
      release_btn();

      // nn_done coincident with the launch pulse is ignored.
      do_reset();
      press(1'b1, 1'b1, 1'b0);
      nn_done = 1'b1;
      tick(1);
      nn_done = 1'b0;
      start_n_pin = 1'b1;
      tick(14);
      check("launch_done_ignored", 32'(busy), 32'd1);
      done(1);
      tick(2);
      check("wait_done_idle", 32'(busy), 32'd0);

      // Counter wraps after 256 launches.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         press(1'b0, 1'b0, 1'b0);
         done(1);
         release_btn();
      end
      check("wrap_req_count", 32'(req_count), 32'd0);
      press(1'b1, 1'b0, 1'b0);
      check("wrap_257", 32'(req_count), 32'd1);
      done(1);
      release_btn();

      // No done: watchdog fires after 100 WAIT cycles when built in, otherwise WAIT persists.
      do_reset();
      press(1'b1, 1'b1, 1'b0);
      tick(100);
      check("to_before_limit", 32'(timeout), 32'd0);
      tick(1);
`ifdef XOR_NN_TIMEOUT_EN
      check("to_at_limit", 32'(timeout), 32'd1);
      start_n_pin = 1'b1;
      tick(14);
      check("to_holdoff_release", 32'(busy), 32'd0);
      check("to_sticky", 32'(timeout), 32'd1);
`else
      check("to_at_limit", 32'(timeout), 32'd0);
      start_n_pin = 1'b1;
      tick(14);
      check("to_still_wait", 32'(busy), 32'd1);
      check("to_off_flag", 32'(timeout), 32'd0);
`endif
      done(1);
      tick(2);
      check("to_idle", 32'(busy), 32'd0);
      press(1'b0, 1'b0, 1'b0);
      done(1);
      release_btn();
      check("to_cleared", 32'(timeout), 32'd0);
      check("sb_drained", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/xor_nn_input_cond.md
Name: xor_nn_input_cond

Overview:
Upstream stage of the xor_nn evaluator. It conditions the raw, asynchronous MKR header pins (active-low start button, x1, x2) with synchronisers and debouncers. It turns each button press into exactly one single-cycle start pulse and holds the x1/x2 operands stable until xor_nn reports done. It runs in the wMEM_CLK domain.

Parameters:
SYNC_STAGES, 2, flip-flops per synchroniser chain (minimum 2)
DEBOUNCE_CYCLES, 1024, consecutive stable cycles required before a debounced level changes
TIMEOUT_CYCLES, 65535, WAIT-state watchdog limit (used only with XOR_NN_TIMEOUT_EN)

Ports:
clk  in  1  system clock (wMEM_CLK)
rst  in  1  synchronous, active-high reset
start_n_pin  in  1  raw async start request, active-low (D5)
x1_pin  in  1  raw async operand x1 (D3)
x2_pin  in  1  raw async operand x2 (D4)
nn_done  in  1  done from xor_nn
nn_start  out  1  one-cycle start pulse to xor_nn
nn_x1  out  1  latched x1 to xor_nn
nn_x2  out  1  latched x2 to xor_nn
busy  out  1  high from LAUNCH through HOLDOFF
req_count  out  8  number of launches issued, wraps at 256
timeout  out  1  sticky watchdog flag; tied 0 when the macro is off

Behaviour:
- Reset: clk is the only clock. rst is synchronous, active-high.
  - Sync chains reset to the inactive level: start_n=1, x1=x2=0. Debounced start_n=1, debounced x1/x2=0.
  - Debounce counters=0, state=IDLE.
  - nn_start=0, nn_x1=0, nn_x2=0, busy=0, req_count=0, timeout=0.
- Synchroniser: SYNC_STAGES flops per pin. There is no logic between stages.
- Debounce, per signal:
  - The counter clears on any cycle where the synced value equals the debounced value, or where the synced value changed from the previous cycle.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the value unchanged, the debounced value takes the synced value and the counter clears.
  - Pin-to-debounced latency is SYNC_STAGES+DEBOUNCE_CYCLES cycles (+1 for async capture).
- Fall detect: the registered previous debounced start_n is 1 and the current value is 0. This is evaluated in IDLE only.
- FSM states IDLE, LAUNCH, WAIT, HOLDOFF:
  - IDLE: busy=0. On fall detect at cycle T, nn_x1/nn_x2 load the debounced x1/x2 at the T edge, and the next state is LAUNCH.
  - LAUNCH: nn_start=1 for exactly this cycle (T+1). req_count increments, mod 256. Next state is WAIT.
  - WAIT: nn_done=1 moves to HOLDOFF. Otherwise the FSM stays in WAIT.
  - HOLDOFF: waits for debounced start_n==1 (button released), then goes to IDLE. A held button therefore never retriggers.
- Operand hold: nn_x1/nn_x2 change only on an IDLE launch, never in LAUNCH, WAIT or HOLDOFF.
- Ignored inputs: nn_done outside WAIT is ignored. A start edge outside IDLE is ignored.
- Simultaneous events: nn_done in the same cycle as the LAUNCH pulse is ignored, because WAIT has not been entered yet.
- Reset mid-operation: all state returns to the reset values, and any in-flight request is abandoned.
  - If the pin is held low through reset, one request fires after the debounce latency. This is intended.
- nn_start and busy are registered (Moore) outputs. There is no combinational input-to-output path.

Optional Feature:
Macro: XOR_NN_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on LAUNCH and increments in WAIT.
  - If the count reaches TIMEOUT_CYCLES before nn_done, the FSM goes to HOLDOFF and timeout sets.
  - timeout stays high until the next LAUNCH or rst.
- Undefined:
  - There is no counter logic, and WAIT waits indefinitely.
  - timeout is driven constant 0, so the port list is identical in both builds.

Test Plan:
(Simulation parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, TIMEOUT_CYCLES=100.)
1. Clean press, x1=1, x2=0: pin low -> one nn_start pulse about 11 cycles later with nn_x1=1, nn_x2=0, busy=1. nn_done pulse 5 cycles later -> HOLDOFF. Release -> IDLE after debounce, busy=0, req_count=1.
2. Bounce: start_n_pin toggles every 3 cycles for 30 cycles, then settles low -> exactly one nn_start pulse, req_count=1.
3. Hold and change: x1/x2 toggle during WAIT and the button is held through done -> nn_x1/nn_x2 unchanged, no second pulse until release and re-press.
4. Reset: rst for 1 cycle in WAIT -> next cycle busy=0, nn_x1=nn_x2=0, req_count=0, nn_start=0. Pin still low -> one new pulse after about 11 cycles.
5. Wrap: 256 complete press/done/release sequences -> req_count=0. Press 257 -> req_count=1.
6. Timeout (XOR_NN_TIMEOUT_EN defined), nn_done never asserted -> timeout=1 after 100 WAIT cycles, FSM in HOLDOFF. Release, press, done -> timeout=0 at the LAUNCH cycle. With the macro undefined -> the same stimulus stays in WAIT with timeout=0.
